// File: rtl/ln_result_packer.sv
// LayerNorm output packer: FP32x4 beats are rounded to BF16x4 (RNE), tagged with
// the row-end flag and buffered in a FWFT FIFO behind an AXI-Stream master.

module ln_bf16_round (
    input  logic [31:0] x_i,
    output logic [15:0] y_o
);
    logic is_nan;
    logic carry;

    assign is_nan = (&x_i[30:23]) & (|x_i[22:0]);
    // Carry out of the low half of x + 0x7FFF + x[16]: above halfway, or exactly halfway with an odd kept lsb.
    assign carry  = x_i[15] & ((|x_i[14:0]) | x_i[16]);
    assign y_o    = is_nan ? {x_i[31], 8'hFF, 7'h40} : (x_i[31:16] + {15'd0, carry});
endmodule

module ln_result_packer #(
    parameter int DATA_NUM   = 192,
    parameter int FIFO_DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stage_start,
    input  logic         in_tvalid,
    input  logic [127:0] in_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [63:0]  m_tdata,
    output logic         m_tlast,
    output logic         overflow,
    output logic         stage_done
);
    localparam int NUM_LANES = 4;
    localparam int STAGES    = 2;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_NUM - 1);

    typedef struct packed {
        logic                       last;
        logic [NUM_LANES-1:0][15:0] data;
    } beat_t;

    logic                       start_q;
    logic                       init;
    logic                       take;
    logic [STAGES-1:0]          vld_pipe_q;
    logic [STAGES-1:0]          vld_pipe_d;
    logic [NUM_LANES-1:0][31:0] in_q;
    logic [NUM_LANES-1:0][15:0] rnd_d;
    logic [NUM_LANES-1:0][15:0] rnd_q;
    logic [CW-1:0]              cnt_q;
    logic [CW-1:0]              cnt_d;
    logic [AW:0]                wr_ptr_q;
    logic [AW:0]                wr_ptr_d;
    logic [AW:0]                rd_ptr_q;
    logic [AW:0]                rd_ptr_d;
    logic                       ovf_q;
    logic                       ovf_d;
    logic                       full;
    logic                       empty;
    logic                       push_req;
    logic                       push;
    logic                       pop;
    beat_t                      head;
    beat_t                      wr_beat;
    beat_t                      mem [FIFO_DEPTH];

    assign init = stage_start & ~start_q;
    assign take = in_tvalid & stage_start & ~init;

    // Input register, then one rounding register per lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            in_q    <= '0;
            rnd_q   <= '0;
        end else begin
            start_q <= stage_start;
            if (take)          in_q  <= in_tdata;
            if (vld_pipe_q[0]) rnd_q <= rnd_d;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        ln_bf16_round u_round (
            .x_i (in_q[l]),
            .y_o (rnd_d[l])
        );
    end

    // FIFO status and handshake
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head     = mem[rd_ptr_q[AW-1:0]];
    assign m_tvalid = ~empty;
    assign pop      = m_tvalid & m_tready;
    assign push_req = vld_pipe_q[STAGES-1];
    // When full, a same-cycle pop frees the head slot the push is about to reuse.
    assign push     = push_req & (~full | pop);

    assign wr_beat.last = (cnt_q == CNT_LAST);
    assign wr_beat.data = rnd_q;

    assign m_tdata    = m_tvalid ? head.data : '0;
    assign m_tlast    = m_tvalid & head.last;
    assign stage_done = pop & head.last;
    assign overflow   = ovf_q;

    always_comb begin
        vld_pipe_d = {vld_pipe_q[STAGES-2:0], take};
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        ovf_d      = ovf_q;
        // Dropped beats still advance the row counter so later rows keep tlast aligned.
        if (push_req) cnt_d = wr_beat.last ? '0 : cnt_q + CW'(1);
        if (push)     wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        if (push_req && !push) ovf_d = 1'b1;
        if (init) begin
            vld_pipe_d = '0;
            cnt_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            ovf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ovf_q      <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !init) mem[wr_ptr_q[AW-1:0]] <= wr_beat;
    end
endmodule
